// File: rtl/clock_pkg.sv
// rtl/clock_pkg.sv - shared types and constants for the alarm-clock button path
package clock_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRESS_DB,
    HELD_DELAY,
    HELD_REPEAT,
    RELEASE_DB
  } channel_state_t;

  // 50 MHz system clock divided down to a 1 ms tick
  localparam int unsigned MS_TICK_CYCLES = 50000;

endpackage

// File: rtl/button_channel.sv
// rtl/button_channel.sv - synchronizer, debounce FSM and auto-repeat for one button
module button_channel
  import clock_pkg::*;
#(
  parameter int unsigned DEBOUNCE_MS     = 20,
  parameter int unsigned REPEAT_DELAY_MS = 500,
  parameter int unsigned REPEAT_RATE_MS  = 100
) (
  input  logic clock,
  input  logic reset_n,
  input  logic tick,
  input  logic raw,
  input  logic repeat_en,
  output logic level,
  output logic press,
  output logic released,
  output logic step
);

  localparam int unsigned HOLD_MAX = (REPEAT_DELAY_MS > REPEAT_RATE_MS) ? REPEAT_DELAY_MS : REPEAT_RATE_MS;
  localparam int DB_W   = $clog2(DEBOUNCE_MS + 1);
  localparam int HOLD_W = $clog2(HOLD_MAX + 1);

  localparam logic [DB_W-1:0]   DB_DONE    = DB_W'(DEBOUNCE_MS);
  localparam logic [HOLD_W-1:0] HOLD_SAT   = HOLD_W'(HOLD_MAX);
  localparam logic [HOLD_W-1:0] DELAY_DONE = HOLD_W'(REPEAT_DELAY_MS);
  localparam logic [HOLD_W-1:0] RATE_DONE  = HOLD_W'(REPEAT_RATE_MS);

  logic sync1, sync2, s;
  channel_state_t state, state_nxt;
  logic [DB_W-1:0]   db_cnt, db_nxt, db_inc;
  logic [HOLD_W-1:0] hold_cnt, hold_nxt, hold_inc;
  logic ret_repeat, ret_nxt;
  logic level_nxt, press_nxt, rel_nxt, step_nxt;

  assign s        = ~sync2;
  assign db_inc   = db_cnt + DB_W'(1);
  assign hold_inc = (tick && hold_cnt != HOLD_SAT) ? hold_cnt + HOLD_W'(1) : hold_cnt;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1      <= 1'b1;
      sync2      <= 1'b1;
      state      <= IDLE;
      db_cnt     <= '0;
      hold_cnt   <= '0;
      ret_repeat <= 1'b0;
      level      <= 1'b0;
      press      <= 1'b0;
      released   <= 1'b0;
      step       <= 1'b0;
    end else begin
      sync1      <= raw;
      sync2      <= sync1;
      state      <= state_nxt;
      db_cnt     <= db_nxt;
      hold_cnt   <= hold_nxt;
      ret_repeat <= ret_nxt;
      level      <= level_nxt;
      press      <= press_nxt;
      released   <= rel_nxt;
      step       <= step_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    db_nxt    = db_cnt;
    hold_nxt  = hold_cnt;
    ret_nxt   = ret_repeat;
    level_nxt = level;
    press_nxt = 1'b0;
    rel_nxt   = 1'b0;
    step_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (s) begin
          db_nxt    = '0;
          state_nxt = PRESS_DB;
        end
      end
      PRESS_DB: begin
        if (!s) begin
          state_nxt = IDLE;
        end else if (tick) begin
          db_nxt = db_inc;
          if (db_inc == DB_DONE) begin
            level_nxt = 1'b1;
            press_nxt = 1'b1;
            step_nxt  = 1'b1;
            hold_nxt  = '0;
            state_nxt = HELD_DELAY;
          end
        end
      end
      HELD_DELAY: begin
        if (!s) begin
          db_nxt    = '0;
          ret_nxt   = 1'b0;
          state_nxt = RELEASE_DB;
        end else if (repeat_en && hold_inc >= DELAY_DONE) begin
          step_nxt  = 1'b1;
          hold_nxt  = '0;
          state_nxt = HELD_REPEAT;
        end else begin
          hold_nxt = hold_inc;
        end
      end
      HELD_REPEAT: begin
        if (!s) begin
          db_nxt    = '0;
          ret_nxt   = 1'b1;
          state_nxt = RELEASE_DB;
        end else if (!repeat_en) begin
          // parked with a full count so re-enabling repeat steps at once
          hold_nxt  = HOLD_SAT;
          state_nxt = HELD_DELAY;
        end else if (hold_inc >= RATE_DONE) begin
          step_nxt = 1'b1;
          hold_nxt = '0;
        end else begin
          hold_nxt = hold_inc;
        end
      end
      RELEASE_DB: begin
        if (s) begin
          state_nxt = ret_repeat ? HELD_REPEAT : HELD_DELAY;
        end else if (tick) begin
          db_nxt = db_inc;
          if (db_inc == DB_DONE) begin
            level_nxt = 1'b0;
            rel_nxt   = 1'b1;
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - shared 1 ms prescaler feeding one conditioner per KEY
module button_conditioner
  import clock_pkg::*;
#(
  parameter int unsigned CLOCK_FREQ_1KHZ = MS_TICK_CYCLES,
  parameter int unsigned NUM_BUTTONS     = 4,
  parameter int unsigned DEBOUNCE_MS     = 20,
  parameter int unsigned REPEAT_DELAY_MS = 500,
  parameter int unsigned REPEAT_RATE_MS  = 100
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic [NUM_BUTTONS-1:0] pb_raw,
  input  logic [NUM_BUTTONS-1:0] repeat_en,
  output logic [NUM_BUTTONS-1:0] pb_level,
  output logic [NUM_BUTTONS-1:0] pb_press,
  output logic [NUM_BUTTONS-1:0] pb_release,
  output logic [NUM_BUTTONS-1:0] pb_step
);

  localparam int PRE_W = (CLOCK_FREQ_1KHZ > 1) ? $clog2(CLOCK_FREQ_1KHZ) : 1;

  logic [PRE_W-1:0] pre_cnt;
  logic tick;

  assign tick = (pre_cnt == PRE_W'(CLOCK_FREQ_1KHZ - 1));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pre_cnt <= '0;
    end else if (tick) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + PRE_W'(1);
    end
  end

  for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_chan
    button_channel #(
      .DEBOUNCE_MS    (DEBOUNCE_MS),
      .REPEAT_DELAY_MS(REPEAT_DELAY_MS),
      .REPEAT_RATE_MS (REPEAT_RATE_MS)
    ) u_chan (
      .clock    (clock),
      .reset_n  (reset_n),
      .tick     (tick),
      .raw      (pb_raw[i]),
      .repeat_en(repeat_en[i]),
      .level    (pb_level[i]),
      .press    (pb_press[i]),
      .released (pb_release[i]),
      .step     (pb_step[i])
    );
  end

endmodule
